local_store_agu: RTL and testbench

Parameterised 2-D address sequencer for one PE local store (kernel or neuron), the next generation of the per-PE store controller. The controller now runs a full row/column walk autonomously after a single start pulse, instead of being stepped command by command. It adds a configurable base, row/column counts, independent strides, start/stall/abort handshakes and a done pulse. Two instances sit in each PE, one per store, driven by the array-level sequencer.

---
 rtl/local_store_agu.sv | 178 +++++++++++++++++
 tb/tb_local_store_agu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/local_store_agu.sv
`default_nettype none
// ============================================================================
// Module   : local_store_agu
// Purpose  : 2-D address sequencer for one PE local store. After one start
//            pulse it walks (n_rows_m1+1) x (n_cols_m1+1) beats, producing
//              addr = base + (row_pos + row_ofst) * row_step
//                          + col_pos + col_ofst          (mod 2^A)
//            with start / stall / abort handshakes and a done pulse.
// Ports    : clk, rst_n            clock, async active-low reset
//            cfg_we/cfg_sel/cfg_data  config write (ignored while busy)
//            start, wr_mode        begin walk; 1 = load walk (column step 1)
//            stall, abort          freeze / terminate the walk
//            addr, addr_valid      current address and live-beat flag
//            write, last           latched wr_mode, final beat flag
//            busy, done            walk in progress, pulse after last beat
// Revision : 1.0 - initial release
// ============================================================================
module local_store_agu #(
  parameter int A     = 7,
  parameter int DEPTH = 2,
  parameter int C_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_sel,
  input  logic [A-1:0]     cfg_data,
  input  logic             start,
  input  logic             wr_mode,
  input  logic             stall,
  input  logic             abort,
  output logic [A-1:0]     addr,
  output logic             addr_valid,
  output logic             write,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [A-1:0]   c_pos_one = 1;
  localparam logic [C_W-1:0] c_idx_one = 1;

  state_t             state_q, state_d;
  logic               write_q, write_d;
  logic [C_W-1:0]     col_idx_q, col_idx_d, row_idx_q, row_idx_d;
  logic [A-1:0]       col_pos_q, col_pos_d, row_pos_q, row_pos_d;
  logic [A-1:0]       base_q, base_d, row_step_q, row_step_d;
  logic [A-1:0]       col_stride_q, col_stride_d, row_incr_q, row_incr_d;
  logic [C_W-1:0]     n_cols_m1_q, n_cols_m1_d, n_rows_m1_q, n_rows_m1_d;
  logic [DEPTH-1:0]   row_ofst_q, row_ofst_d, col_ofst_q, col_ofst_d;

  logic               w_col_term, w_row_term;
  logic [2*A-1:0]     w_row_sum, w_prod, w_full;
  logic               w_unused_hi;

  // Address datapath is 2A bits wide; only the final sum is wrapped to A bits.
  assign w_row_sum = {{A{1'b0}}, row_pos_q} + {{(2*A-DEPTH){1'b0}}, row_ofst_q};
  assign w_prod    = w_row_sum * {{A{1'b0}}, row_step_q};
  assign w_full    = {{A{1'b0}}, base_q} + w_prod + {{A{1'b0}}, col_pos_q}
                   + {{(2*A-DEPTH){1'b0}}, col_ofst_q};
  assign w_unused_hi = ^w_full[2*A-1:A];

  assign w_col_term = (col_idx_q == n_cols_m1_q);
  assign w_row_term = (row_idx_q == n_rows_m1_q);

  assign addr       = w_full[A-1:0];
  assign addr_valid = (state_q == S_RUN) & ~stall & ~abort;
  assign last       = addr_valid & w_col_term & w_row_term;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign write      = write_q;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    col_pos_d    = col_pos_q;
    row_pos_d    = row_pos_q;
    base_d       = base_q;
    row_step_d   = row_step_q;
    col_stride_d = col_stride_q;
    row_incr_d   = row_incr_q;
    n_cols_m1_d  = n_cols_m1_q;
    n_rows_m1_d  = n_rows_m1_q;
    row_ofst_d   = row_ofst_q;
    col_ofst_d   = col_ofst_q;

    // Config is locked for the whole walk, including the done cycle.
    if (cfg_we && (state_q == S_IDLE)) begin
      case (cfg_sel)
        3'd0:    base_d       = cfg_data;
        3'd1:    row_step_d   = cfg_data;
        3'd2:    col_stride_d = cfg_data;
        3'd3:    row_incr_d   = cfg_data;
        3'd4:    n_cols_m1_d  = cfg_data[C_W-1:0];
        3'd5:    n_rows_m1_d  = cfg_data[C_W-1:0];
        3'd6:    row_ofst_d   = cfg_data[DEPTH-1:0];
        default: col_ofst_d   = cfg_data[DEPTH-1:0];
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          write_d   = wr_mode;
          col_idx_d = '0;
          row_idx_d = '0;
          col_pos_d = '0;
          row_pos_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!stall) begin
          if (col_idx_q < n_cols_m1_q) begin
            col_idx_d = col_idx_q + c_idx_one;
            col_pos_d = col_pos_q + (write_q ? c_pos_one : col_stride_q);
          end else begin
            col_idx_d = '0;
            col_pos_d = '0;
            row_idx_d = row_idx_q + c_idx_one;
            row_pos_d = row_pos_q + row_incr_q;
          end
          if (w_col_term && w_row_term) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      col_idx_q    <= '0;
      row_idx_q    <= '0;
      col_pos_q    <= '0;
      row_pos_q    <= '0;
      base_q       <= '0;
      row_step_q   <= c_pos_one;
      col_stride_q <= c_pos_one;
      row_incr_q   <= c_pos_one;
      n_cols_m1_q  <= '0;
      n_rows_m1_q  <= '0;
      row_ofst_q   <= '0;
      col_ofst_q   <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      col_pos_q    <= col_pos_d;
      row_pos_q    <= row_pos_d;
      base_q       <= base_d;
      row_step_q   <= row_step_d;
      col_stride_q <= col_stride_d;
      row_incr_q   <= row_incr_d;
      n_cols_m1_q  <= n_cols_m1_d;
      n_rows_m1_q  <= n_rows_m1_d;
      row_ofst_q   <= row_ofst_d;
      col_ofst_q   <= col_ofst_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_local_store_agu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_local_store_agu
// Purpose  : Self-checking bench for local_store_agu. Expected beat streams
//            come from a nested-loop address model driven by a shadow copy
//            of the configuration registers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_local_store_agu;

  localparam int A     = 7;
  localparam int DEPTH = 2;
  localparam int C_W   = 4;
  localparam int MASK  = (1 << A) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           cfg_we = 1'b0;
  logic [2:0]     cfg_sel = '0;
  logic [A-1:0]   cfg_data = '0;
  logic           start = 1'b0;
  logic           wr_mode = 1'b0;
  logic           stall = 1'b0;
  logic           abort = 1'b0;
  logic [A-1:0]   addr;
  logic           addr_valid, write, last, busy, done;

  int checks = 0;
  int errors = 0;
  int m_cfg[8];     // shadow config: base,row_step,col_stride,row_incr,ncm1,nrm1,rofs,cofs
  int exp_q[$];

  local_store_agu #(.A(A), .DEPTH(DEPTH), .C_W(C_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .start      (start),
    .wr_mode    (wr_mode),
    .stall      (stall),
    .abort      (abort),
    .addr       (addr),
    .addr_valid (addr_valid),
    .write      (write),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = '{0, 1, 1, 1, 0, 0, 0, 0};
  endtask

  // Write one config register while idle; the shadow copy keeps field widths.
  task automatic cfg_write(input int sel, input int data);
    cfg_we = 1'b1; cfg_sel = sel[2:0]; cfg_data = data[A-1:0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
    case (sel)
      4, 5:    m_cfg[sel] = data & ((1 << C_W) - 1);
      6, 7:    m_cfg[sel] = data & ((1 << DEPTH) - 1);
      default: m_cfg[sel] = data & MASK;
    endcase
  endtask

  // Row-major list of every address the walk must emit.
  task automatic build(input bit wr);
    exp_q.delete();
    for (int r = 0; r <= m_cfg[5]; r++)
      for (int c = 0; c <= m_cfg[4]; c++)
        exp_q.push_back((m_cfg[0] + (r * m_cfg[3] + m_cfg[6]) * m_cfg[1]
                         + c * (wr ? 1 : m_cfg[2]) + m_cfg[7]) & MASK);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_addr"},  32'(addr), 0);
    chk({tag, "_valid"}, 32'(addr_valid), 0);
    chk({tag, "_write"}, 32'(write), 0);
    chk({tag, "_last"},  32'(last), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  // smode: 0 no stall, 1 random stall, 2 two-cycle stall once two beats are out.
  // abort_at: beat index at which abort is raised (-1 = never).
  // poke: attempt config writes mid-walk (must be ignored).
  task automatic run_walk(input bit wr, input int smode, input int abort_at, input bit poke);
    int  n, k, st_ct, cyc;
    bit  fin, aborted, ev;
    build(wr);
    n = exp_q.size(); k = 0; st_ct = 0; cyc = 0; fin = 0; aborted = 0;
    start = 1'b1; wr_mode = wr;
    @(posedge clk); #1;
    start = 1'b0; wr_mode = 1'b0;
    while (!fin) begin
      stall = 1'b0; abort = 1'b0;
      if (smode == 1) stall = ($urandom_range(0, 3) == 0);
      if (smode == 2 && k == 2 && st_ct < 2) begin stall = 1'b1; st_ct++; end
      if (k == abort_at) abort = 1'b1;
      if (poke && k == 1) begin
        cfg_we = 1'b1; cfg_sel = 3'($urandom); cfg_data = A'($urandom);
      end
      ev = !stall && !abort;
      @(negedge clk);
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      chk("addr", 32'(addr), 32'(exp_q[k]));
      chk("addr_valid", 32'(addr_valid), 32'(ev));
      if (ev) begin
        chk("write", 32'(write), 32'(wr));
        chk("last", 32'(last), 32'(k == n - 1));
      end else begin
        chk("last_quiet", 32'(last), 0);
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (abort) begin
        aborted = 1; fin = 1;
      end else if (!stall) begin
        k++;
        if (k == n) fin = 1;
      end
      cyc++;
      if (!fin && cyc > 2000) begin
        chk("walk_timeout", 0, 1);
        fin = 1;
      end
    end
    stall = 1'b0; abort = 1'b0;
    if (aborted) begin
      @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      repeat (2) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_no_done", 32'(done), 0);
      end
    end else begin
      @(negedge clk);
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 1);
      chk("done_valid", 32'(addr_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1x1 walk with reset config.
    run_walk(1'b0, 0, -1, 1'b0);

    // Load walk 4x2 with row_step 8: 0..3, 8..11.
    cfg_write(1, 8); cfg_write(4, 3); cfg_write(5, 1);
    run_walk(1'b1, 0, -1, 1'b0);
    run_walk(1'b1, 2, -1, 1'b0);
    run_walk(1'b1, 0, 1, 1'b0);

    // Strided read with offsets: 9, 11, 25, 27.
    cfg_write(2, 2); cfg_write(3, 2); cfg_write(4, 1); cfg_write(5, 1);
    cfg_write(6, 1); cfg_write(7, 1);
    run_walk(1'b0, 0, -1, 1'b0);

    // Wrap: 120 then 0.
    cfg_write(0, 120); cfg_write(2, 1); cfg_write(3, 1); cfg_write(4, 0);
    cfg_write(6, 0); cfg_write(7, 0);
    run_walk(1'b0, 0, -1, 1'b0);

    // Config lockout: pokes during a walk leave this and the next walk intact.
    cfg_write(0, 3); cfg_write(4, 2); cfg_write(5, 2); cfg_write(2, 5);
    run_walk(1'b1, 1, -1, 1'b1);
    run_walk(1'b0, 0, -1, 1'b0);

    // start together with abort in IDLE is refused.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 32'(busy), 0);
    @(posedge clk); #1;

    // Randomized walks.
    for (int i = 0; i < 25; i++) begin
      cfg_write(0, int'($urandom_range(0, MASK)));
      cfg_write(1, int'($urandom_range(0, MASK)));
      cfg_write(2, int'($urandom_range(0, MASK)));
      cfg_write(3, int'($urandom_range(0, MASK)));
      cfg_write(4, int'($urandom_range(0, 3)));
      cfg_write(5, int'($urandom_range(0, 3)));
      cfg_write(6, int'($urandom_range(0, 3)));
      cfg_write(7, int'($urandom_range(0, 3)));
      run_walk(1'($urandom), 1,
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1, 1'b0);
    end

    // Reset mid-walk: outputs clear at once and config reverts.
    cfg_write(0, 5); cfg_write(4, 3); cfg_write(5, 2);
    start = 1'b1; wr_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_mode = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_quiet("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    run_walk(1'b0, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t: got 0 expected 1", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
